// File: rtl/ahb_rr_master.sv
// ahb_rr_master: two-port round-robin AHB-lite master.
// Two local requesters share one AHB-lite slave. Single NONSEQ transfers are
// issued with overlapped address and data phases; hready low freezes both.
//
// Ports:
//   hclk, hresetn            clock, async active-low reset
//   req/we/addr/wdata 0,1    requester inputs, held until gnt
//   gnt0/gnt1                one-cycle pulse: request entered address phase
//   done0/done1              one-cycle pulse: data phase completed
//   rdata                    read data, valid with done of a read
//   hselx/htrans/haddr/hwrite/hwdata   AHB master outputs (registered)
//   hrdata/hready            AHB slave responses
module ahb_rr_master #(
  parameter int unsigned addrWidth = 8,
  parameter int unsigned dataWidth = 32
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [addrWidth-1:0] addr0,
  input  logic [dataWidth-1:0] wdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [addrWidth-1:0] addr1,
  input  logic [dataWidth-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic [dataWidth-1:0] rdata,
  output logic                 hselx,
  output logic [1:0]           htrans,
  output logic [addrWidth-1:0] haddr,
  output logic                 hwrite,
  output logic [dataWidth-1:0] hwdata,
  input  logic [dataWidth-1:0] hrdata,
  input  logic                 hready
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Address-phase slot extras (htrans/haddr/hwrite live in the outputs)
  logic                 ap_id;
  logic [dataWidth-1:0] ap_wdata;
  // Data-phase slot
  logic                 dp_valid;
  logic                 dp_id;
  logic                 dp_we;
  // Last-granted requester
  logic                 last_id;

  logic                 cand0_c;
  logic                 cand1_c;
  logic                 win_c;
  logic                 win_id_c;
  logic [addrWidth-1:0] win_addr_c;
  logic                 win_we_c;
  logic [dataWidth-1:0] win_wdata_c;

  // Arbitration: a requester whose gnt is currently high is masked, so a
  // req still asserted in its grant cycle does not count as a new request.
  always_comb begin
    cand0_c     = req0 & ~gnt0;
    cand1_c     = req1 & ~gnt1;
    win_c       = cand0_c | cand1_c;
    win_id_c    = (cand0_c && cand1_c) ? ~last_id : cand1_c;
    win_addr_c  = win_id_c ? addr1  : addr0;
    win_we_c    = win_id_c ? we1    : we0;
    win_wdata_c = win_id_c ? wdata1 : wdata0;
  end

  // Pipeline registers; everything except the pulses advances only on hready
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      htrans   <= HTRANS_IDLE;
      hselx    <= 1'b0;
      haddr    <= '0;
      hwrite   <= 1'b0;
      hwdata   <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rdata    <= '0;
      ap_id    <= 1'b0;
      ap_wdata <= '0;
      dp_valid <= 1'b0;
      dp_id    <= 1'b0;
      dp_we    <= 1'b0;
      last_id  <= 1'b1;
    end else begin
      // Pulses are never stretched, even across a stall
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (hready) begin
        // Retire the data phase
        if (dp_valid) begin
          if (dp_id) done1 <= 1'b1;
          else       done0 <= 1'b1;
          if (!dp_we) rdata <= hrdata;
        end
        // Address phase moves to data phase
        dp_valid <= (htrans == HTRANS_NONSEQ);
        if (htrans == HTRANS_NONSEQ) begin
          dp_id <= ap_id;
          dp_we <= hwrite;
          if (hwrite) hwdata <= ap_wdata;
        end
        // Load a new address phase from the winner
        if (win_c) begin
          htrans   <= HTRANS_NONSEQ;
          hselx    <= 1'b1;
          haddr    <= win_addr_c;
          hwrite   <= win_we_c;
          ap_wdata <= win_wdata_c;
          ap_id    <= win_id_c;
          last_id  <= win_id_c;
          if (win_id_c) gnt1 <= 1'b1;
          else          gnt0 <= 1'b1;
        end else begin
          htrans <= HTRANS_IDLE;
          hselx  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_rr_master.sv
// Directed bench for ahb_rr_master with a simple memory slave model.
module tb_ahb_rr_master;

  logic        hclk;
  logic        hresetn;
  logic        req0, we0, req1, we1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] rdata;
  logic        hselx;
  logic [1:0]  htrans;
  logic [7:0]  haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;

  int n_checks;
  int n_fail;

  ahb_rr_master #(.addrWidth(8), .dataWidth(32)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .hselx(hselx), .htrans(htrans), .haddr(haddr),
    .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata), .hready(hready)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Memory slave: address phase captured on hready edges, write data stored
  // at the end of the data phase, read data driven from the captured address.
  logic [31:0] mem [0:255];
  logic [7:0]  s_addr;
  logic        s_act;
  logic        s_we;

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      s_act  <= 1'b0;
      s_we   <= 1'b0;
      s_addr <= 8'h00;
    end else if (hready) begin
      if (s_act && s_we) mem[s_addr] <= hwdata;
      s_act  <= hselx && (htrans == 2'b10);
      s_addr <= haddr;
      s_we   <= hwrite;
    end
  end

  assign hrdata = mem[s_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    hresetn  = 1'b0;
    hready   = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_htrans", 32'(htrans), 32'h0);
    chk("rst_hselx",  32'(hselx),  32'h0);
    chk("rst_haddr",  32'(haddr),  32'h0);
    chk("rst_hwdata", hwdata,      32'h0);
    chk("rst_pulses", 32'({gnt0, gnt1, done0, done1}), 32'h0);
    hresetn = 1'b1;

    // Idle: no requests for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_htrans", 32'(htrans), 32'h0);
      chk("idle_hselx",  32'(hselx),  32'h0);
      chk("idle_pulses", 32'({gnt0, gnt1, done0, done1}), 32'h0);
    end

    // Write 0xDEADBEEF to 0x10, then read it back
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 32'hDEADBEEF;
    tick();                                   // edge 1
    chk("wr_gnt0",   32'(gnt0),   32'h1);
    chk("wr_htrans", 32'(htrans), 32'h2);
    chk("wr_hselx",  32'(hselx),  32'h1);
    chk("wr_haddr",  32'(haddr),  32'h10);
    chk("wr_hwrite", 32'(hwrite), 32'h1);
    we0 = 1'b0; wdata0 = 32'h0;               // read posted during grant cycle: masked
    tick();                                   // edge 2
    chk("wr_gnt_pulse", 32'(gnt0),   32'h0);
    chk("wr_mask_idle", 32'(htrans), 32'h0);
    chk("wr_hwdata",    hwdata,      32'hDEADBEEF);
    chk("wr_no_done",   32'(done0),  32'h0);
    tick();                                   // edge 3
    chk("wr_done0", 32'(done0),  32'h1);
    chk("rd_gnt0",  32'(gnt0),   32'h1);
    chk("rd_hwrite", 32'(hwrite), 32'h0);
    req0 = 1'b0;
    tick();                                   // edge 4
    chk("rd_done_wait", 32'(done0), 32'h0);
    tick();                                   // edge 5
    chk("rd_done0", 32'(done0), 32'h1);
    chk("rd_rdata", rdata,      32'hDEADBEEF);

    // Reset mid-transfer: aborted write must not complete
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h33; wdata1 = 32'h12345678;
    tick();
    chk("ab_gnt1", 32'(gnt1), 32'h1);
    req1 = 1'b0;
    #2 hresetn = 1'b0;
    #1;
    chk("ab_htrans", 32'(htrans), 32'h0);
    chk("ab_hselx",  32'(hselx),  32'h0);
    chk("ab_haddr",  32'(haddr),  32'h0);
    chk("ab_hwrite", 32'(hwrite), 32'h0);
    chk("ab_rdata",  rdata,       32'h0);
    chk("ab_gnt1_clr", 32'(gnt1), 32'h0);
    tick();
    hresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_no_done", 32'({done0, done1}), 32'h0);
    end

    // Contention: both held, alternate starting with requester 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h21;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("ct_gnt0",   32'(gnt0),   32'((i % 2) == 0));
      chk("ct_gnt1",   32'(gnt1),   32'((i % 2) == 1));
      chk("ct_htrans", 32'(htrans), 32'h2);
      chk("ct_haddr",  32'(haddr),  ((i % 2) == 0) ? 32'h20 : 32'h21);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("ct_drain_idle", 32'(htrans), 32'h0);
    tick(); tick();

    // Stall: 3 low-hready cycles during a read's data phase
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
    tick();                                   // edge 1
    chk("st_gnt1", 32'(gnt1), 32'h1);
    req1 = 1'b0;
    tick();                                   // edge 2: read in data phase
    chk("st_gnt_pulse", 32'(gnt1), 32'h0);
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_htrans", 32'(htrans), 32'h0);
      chk("st_haddr",  32'(haddr),  32'h10);
      chk("st_hwrite", 32'(hwrite), 32'h0);
      chk("st_hwdata", hwdata,      32'h0);
      chk("st_no_done", 32'(done1), 32'h0);
    end
    hready = 1'b1;
    tick();
    chk("st_done1", 32'(done1), 32'h1);
    chk("st_rdata", rdata,      32'hDEADBEEF);
    tick();
    chk("st_done_pulse", 32'(done1), 32'h0);

    // Request withdrawn before grant (bus stalled meanwhile)
    hready = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    tick();
    chk("wd_no_gnt_stall", 32'(gnt0), 32'h0);
    req0 = 1'b0;
    hready = 1'b1;
    tick();
    chk("wd_no_gnt",  32'(gnt0),   32'h0);
    chk("wd_htrans",  32'(htrans), 32'h0);

    // Mixed pipeline: req1 writes k, then req0 reads k, back to back
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h00; wdata1 = 32'hC0DE0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mx_gnt1", 32'(gnt1), 32'h1);
      chk("mx_hwrite", 32'(hwrite), 32'h1);
      if (k > 0) chk("mx_wr_done1", 32'(done1), 32'h1);
      req1 = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'(k);
      tick();
      chk("mx_gnt0", 32'(gnt0), 32'h1);
      chk("mx_haddr", 32'(haddr), 32'(k));
      if (k > 0) begin
        chk("mx_rd_done0", 32'(done0), 32'h1);
        chk("mx_rdata", rdata, 32'hC0DE0000 + 32'(k - 1));
      end
      req0 = 1'b0;
      if (k < 3) begin
        req1 = 1'b1; addr1 = 8'(k + 1); wdata1 = 32'hC0DE0000 + 32'(k + 1);
      end
    end
    tick();
    chk("mx_last_wr_done", 32'(done1), 32'h1);
    tick();
    chk("mx_last_rd_done", 32'(done0), 32'h1);
    chk("mx_last_rdata",   rdata,      32'hC0DE0003);
    tick();
    chk("mx_quiet", 32'({gnt0, gnt1, done0, done1}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
